// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared mode encodings and default tap masks for lfsr_param
package lfsr_pkg;

    // Step-function selector as sampled on the mode input
    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    // Maximal-length defaults; Fibonacci masks select state bits XORed into the MSB,
    // Galois masks are toggled into the right-shifted state when bit 0 falls out
    localparam logic [3:0]  FIB_TAPS_4  = 4'b0011;
    localparam logic [3:0]  GAL_TAPS_4  = 4'b1001;
    localparam logic [7:0]  FIB_TAPS_8  = 8'b0001_1101;
    localparam logic [7:0]  GAL_TAPS_8  = 8'b1011_1000;
    localparam logic [15:0] FIB_TAPS_16 = 16'h6801;
    localparam logic [15:0] GAL_TAPS_16 = 16'hB400;

    localparam logic [3:0]  RESET_SEED_4 = 4'b0001;

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational one-step LFSR next-state function
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] FIB_TAPS = FIB_TAPS_4,
    parameter logic [WIDTH-1:0] GAL_TAPS = GAL_TAPS_4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             mode,
    output logic [WIDTH-1:0] nxt
);

    logic             fib_fb;
    logic [WIDTH-1:0] fib_nxt;
    logic [WIDTH-1:0] gal_nxt;

    // Both step forms are computed every cycle; mode only picks which one is used
    always_comb begin
        fib_fb  = ^(cur & FIB_TAPS);
        fib_nxt = {fib_fb, cur[WIDTH-1:1]};
        gal_nxt = {1'b0, cur[WIDTH-1:1]} ^ ({WIDTH{cur[0]}} & GAL_TAPS);
        nxt     = (mode == MODE_GAL) ? gal_nxt : fib_nxt;
    end

endmodule

// File: rtl/lfsr_param.sv
// rtl/lfsr_param.sv - parametrised Fibonacci/Galois LFSR with lock-up recovery and period monitor
module lfsr_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] FIB_TAPS   = FIB_TAPS_4,
    parameter logic [WIDTH-1:0] GAL_TAPS   = GAL_TAPS_4,
    parameter logic [WIDTH-1:0] RESET_SEED = RESET_SEED_4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             mode,
    output logic [WIDTH-1:0] state,
    output logic             serial_out,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             wrap_q;
    logic [WIDTH-1:0] step_nxt;

    lfsr_next #(
        .WIDTH    (WIDTH),
        .FIB_TAPS (FIB_TAPS),
        .GAL_TAPS (GAL_TAPS)
    ) u_next (
        .cur  (state_q),
        .mode (mode),
        .nxt  (step_nxt)
    );

    // State, reference seed, step counter and period monitor; load beats enable beats hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RESET_SEED;
            seed_q   <= RESET_SEED;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else if (load) begin
            state_q <= seed;
            seed_q  <= seed;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (enable) begin
            if (state_q == '0) begin
                // All-zero is a fixed point of both step forms, so restart the sequence
                state_q <= RESET_SEED;
                seed_q  <= RESET_SEED;
                cnt_q   <= '0;
                wrap_q  <= 1'b0;
            end else begin
                state_q <= step_nxt;
                if (step_nxt == seed_q) begin
                    wrap_q   <= 1'b1;
                    period_q <= cnt_q + ONE;
                    cnt_q    <= '0;
                end else begin
                    wrap_q <= 1'b0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign state      = state_q;
    assign serial_out = state_q[0];
    assign lockup     = (state_q == '0);
    assign wrap       = wrap_q;
    assign period     = period_q;

endmodule

// File: tb/tb_lfsr_param.sv
// tb/tb_lfsr_param.sv - self-checking bench for lfsr_param
module tb_lfsr_param;
    import lfsr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       load, enable, mode;
    logic [3:0] seed;
    logic [3:0] state, period;
    logic       serial_out, lockup, wrap;

    logic       load8, enable8, mode8;
    logic [7:0] seed8;
    logic [7:0] state8, period8;
    logic       serial_out8, lockup8, wrap8;

    lfsr_param dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .seed       (seed),
        .enable     (enable),
        .mode       (mode),
        .state      (state),
        .serial_out (serial_out),
        .lockup     (lockup),
        .wrap       (wrap),
        .period     (period)
    );

    lfsr_param #(
        .WIDTH      (8),
        .FIB_TAPS   (FIB_TAPS_8),
        .GAL_TAPS   (GAL_TAPS_8),
        .RESET_SEED (8'h01)
    ) dut8 (
        .clk        (clk),
        .reset      (reset),
        .load       (load8),
        .seed       (seed8),
        .enable     (enable8),
        .mode       (mode8),
        .state      (state8),
        .serial_out (serial_out8),
        .lockup     (lockup8),
        .wrap       (wrap8),
        .period     (period8)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference step: Fibonacci = parity of tapped bits shifted into the MSB,
    // Galois = right shift then XOR the toggle mask if a one fell out of bit 0
    function automatic int ref_next(input int w, input int s, input bit m,
                                    input int fib, input int gal);
        int p;
        if (!m) begin
            p = 0;
            for (int i = 0; i < w; i++)
                if ((fib >> i) & 1) p = p ^ ((s >> i) & 1);
            return (s >> 1) | (p << (w - 1));
        end
        return (s >> 1) ^ ((s & 1) ? gal : 0);
    endfunction

    // Behavioural model of the 4-bit instance
    int m_state, m_seed, m_cnt, m_period, m_wrap;

    task automatic model_reset();
        m_state = 1; m_seed = 1; m_cnt = 0; m_period = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit ld, input int sd, input bit en, input bit md);
        int nx;
        if (ld) begin
            m_state = sd; m_seed = sd; m_cnt = 0; m_wrap = 0;
        end else if (en) begin
            if (m_state == 0) begin
                m_state = 1; m_seed = 1; m_cnt = 0; m_wrap = 0;
            end else begin
                nx = ref_next(4, m_state, md, 3, 9);
                if (nx == m_seed) begin
                    m_wrap = 1; m_period = (m_cnt + 1) % 16; m_cnt = 0;
                end else begin
                    m_wrap = 0;
                    if (m_cnt < 15) m_cnt++;
                end
                m_state = nx;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    typedef struct {
        bit         ld;
        logic [3:0] sd;
        bit         en;
        bit         md;
        logic [3:0] st;
        bit         wr;
        logic [3:0] per;
        bit         lk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit ld, input logic [3:0] sd, input bit en, input bit md,
                                input logic [3:0] st, input bit wr, input logic [3:0] per,
                                input bit lk);
        vec_t v;
        v.ld = ld; v.sd = sd; v.en = en; v.md = md;
        v.st = st; v.wr = wr; v.per = per; v.lk = lk;
        vecs.push_back(v);
    endfunction

    logic [3:0] fseq [15];
    logic [3:0] gseq [15];

    initial begin
        int exp8;
        fseq = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
        gseq = '{4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5, 4'hB,
                 4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};

        for (int k = 0; k < 15; k++)
            add(0, 4'h0, 1, 0, fseq[k], k == 14, (k == 14) ? 4'd15 : 4'd0, 0);
        add(1, 4'h1, 0, 1, 4'h1, 0, 4'd15, 0);
        for (int k = 0; k < 15; k++)
            add(0, 4'h0, 1, 1, gseq[k], k == 14, 4'd15, 0);
        add(1, 4'h0, 0, 1, 4'h0, 0, 4'd15, 1);
        add(0, 4'h0, 1, 1, 4'h1, 0, 4'd15, 0);
        add(1, 4'hB, 1, 0, 4'hB, 0, 4'd15, 0);
        for (int k = 0; k < 5; k++)
            add(0, 4'h0, 0, 0, 4'hB, 0, 4'd15, 0);
        for (int k = 1; k <= 15; k++)
            add(0, 4'h0, 1, 0, fseq[(6 + k) % 15], k == 15, 4'd15, 0);
        add(0, 4'h0, 1, 0, fseq[7], 0, 4'd15, 0);

        reset = 1'b0; load = 1'b0; enable = 1'b0; mode = 1'b0; seed = '0;
        load8 = 1'b0; enable8 = 1'b0; mode8 = 1'b0; seed8 = '0;
        tick();
        tick();
        chk("reset_state", state, 4'h1);
        chk("reset_serial", serial_out, 1'b1);
        chk("reset_lockup", lockup, 1'b0);
        chk("reset_wrap", wrap, 1'b0);
        chk("reset_period", period, 4'h0);
        chk("reset_state8", state8, 8'h01);
        reset = 1'b1;

        foreach (vecs[i]) begin
            load = vecs[i].ld; seed = vecs[i].sd; enable = vecs[i].en; mode = vecs[i].md;
            tick();
            chk($sformatf("vec%0d_state", i), state, vecs[i].st);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].wr);
            chk($sformatf("vec%0d_period", i), period, vecs[i].per);
            chk($sformatf("vec%0d_lockup", i), lockup, vecs[i].lk);
        end
        load = 1'b0; enable = 1'b0;

        // Reset in the middle of a run: takes effect without waiting for a clock edge
        reset = 1'b0;
        tick();
        reset = 1'b1;
        enable = 1'b1; mode = 1'b0;
        repeat (7) tick();
        chk("mid_run_state", state, 4'hB);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_state", state, 4'h1);
        chk("async_reset_wrap", wrap, 1'b0);
        chk("async_reset_period", period, 4'h0);
        tick();
        reset = 1'b1;
        enable = 1'b0;

        // 8-bit maximal-length run from seed 01
        load8 = 1'b1; seed8 = 8'h01; mode8 = 1'b0;
        tick();
        chk("w8_load", state8, 8'h01);
        load8 = 1'b0; enable8 = 1'b1;
        exp8 = 1;
        for (int i = 0; i < 255; i++) begin
            tick();
            exp8 = ref_next(8, exp8, 1'b0, 32'h1D, 32'hB8);
            chk($sformatf("w8_state%0d", i), state8, exp8);
            chk($sformatf("w8_wrap%0d", i), wrap8, i == 254);
            if (i == 253) chk("w8_period_before", period8, 8'd0);
        end
        chk("w8_period", period8, 8'd255);
        chk("w8_end_state", state8, 8'h01);
        enable8 = 1'b0;

        // Randomised run of the 4-bit instance against the model
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        mode = 1'b0;
        for (int c = 0; c < 600; c++) begin
            load   = ($urandom_range(19) == 0);
            seed   = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
            enable = ($urandom_range(3) != 0);
            if ($urandom_range(24) == 0) mode = ~mode;
            tick();
            model_step(load, seed, enable, mode);
            chk($sformatf("rnd%0d_state", c), state, m_state);
            chk($sformatf("rnd%0d_serial", c), serial_out, m_state & 1);
            chk($sformatf("rnd%0d_lockup", c), lockup, m_state == 0);
            chk($sformatf("rnd%0d_wrap", c), wrap, m_wrap);
            chk($sformatf("rnd%0d_period", c), period, m_period);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
